// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared binary16 types, constants and special-operand classification for fdiv16
package fp16_pkg;

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RD  = 2'b10,
    RM_RU  = 2'b11
  } roundmode_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [14:0] MAXNUM  = 15'h7BFF;
  localparam int          BIAS    = 15;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    ROUND,
    DONE
  } state_e;

  typedef struct packed {
    logic        hit;
    logic [4:0]  flags;
    logic [15:0] result;
  } special_t;

  // Result of a/b when either operand is NaN, inf or zero; hit=0 means both are finite nonzero.
  function automatic special_t special_case(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn;
    special_t s;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_snan = a_nan && !a[9];
    b_snan = b_nan && !b[9];
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    sgn    = a[15] ^ b[15];
    s.hit    = 1'b1;
    s.flags  = 5'd0;
    s.result = 16'd0;
    if (a_nan || b_nan) begin
      s.result         = QNAN;
      s.flags[FLAG_NV] = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      s.result         = QNAN;
      s.flags[FLAG_NV] = 1'b1;
    end else if (a_inf) begin
      s.result = {sgn, POS_INF[14:0]};
    end else if (b_zero) begin
      s.result         = {sgn, POS_INF[14:0]};
      s.flags[FLAG_DZ] = 1'b1;
    end else if (b_inf || a_zero) begin
      s.result = {sgn, 15'd0};
    end else begin
      s.hit = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/lzc11.sv
// rtl/lzc11.sv - 11-bit leading-zero counter used to normalise subnormal significands
module lzc11 (
  input  logic [10:0] a,
  output logic [3:0]  cnt
);

  // Highest set bit wins; an all-zero input reports 11.
  always_comb begin
    cnt = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (a[i]) cnt = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fdiv16.sv
// rtl/fdiv16.sv - binary16 divider, 15-cycle restoring datapath; FDIV16_EARLY_OUT_EN shortcuts special operands
module fdiv16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e            state_q, state_d;
  logic [15:0]       x_q, x_d, y_q, y_d;
  roundmode_e        rm_q, rm_d;
  logic [12:0]       rem_q, rem_d, quo_q, quo_d;
  logic [10:0]       div_q, div_d;
  logic signed [7:0] eq_q, eq_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  special_t          spec_q, spec_d;
  logic [15:0]       result_q, result_d;
  logic [4:0]        flags_q, flags_d;

  // Operand unpack and subnormal normalisation
  logic [10:0]       mx_raw, my_raw, mx_n, my_n;
  logic [3:0]        lz_x, lz_y;
  logic [4:0]        ex_eff, ey_eff;
  logic signed [7:0] ex, ey;

  assign mx_raw = {|x_q[14:10], x_q[9:0]};
  assign my_raw = {|y_q[14:10], y_q[9:0]};
  assign ex_eff = (x_q[14:10] == 5'd0) ? 5'd1 : x_q[14:10];
  assign ey_eff = (y_q[14:10] == 5'd0) ? 5'd1 : y_q[14:10];

  lzc11 u_lzc_x (.a(mx_raw), .cnt(lz_x));
  lzc11 u_lzc_y (.a(my_raw), .cnt(lz_y));

  assign mx_n = mx_raw << lz_x;
  assign my_n = my_raw << lz_y;
  assign ex   = $signed({3'b000, ex_eff}) - $signed({4'b0000, lz_x});
  assign ey   = $signed({3'b000, ey_eff}) - $signed({4'b0000, lz_y});

`ifdef FDIV16_EARLY_OUT_EN
  special_t early;
  assign early = special_case(x, y);
`endif

  logic [7:0]  sh_raw, e_adj;
  logic [3:0]  sh_c;
  logic [12:0] lost_mask, q_sh;
  logic [10:0] mant;
  logic        rb, st, inexact, inc, ovf, tiny;
  logic [17:0] mag;
  logic [15:0] rnd_result;
  logic [4:0]  rnd_flags;

  // Denormalise tiny quotients, then round with carry rippling into the exponent field
  always_comb begin
    sh_raw = 8'd1 - $unsigned(eq_q);
    if (eq_q >= 8'sd1) begin
      sh_c  = 4'd0;
      e_adj = $unsigned(eq_q) - 8'd1;
    end else begin
      sh_c  = (sh_raw > 8'd13) ? 4'd13 : sh_raw[3:0];
      e_adj = 8'd0;
    end
    lost_mask = (13'd1 << sh_c) - 13'd1;
    q_sh      = quo_q >> sh_c;
    mant      = q_sh[12:2];
    rb        = q_sh[1];
    st        = q_sh[0] | (|(quo_q & lost_mask)) | (|rem_q);
    inexact   = rb | st;
    case (rm_q)
      RM_RZ:   inc = 1'b0;
      RM_RNE:  inc = rb & (st | mant[0]);
      RM_RD:   inc = inexact & sign_q;
      RM_RU:   inc = inexact & ~sign_q;
      default: inc = 1'b0;
    endcase
    // Hidden bit of a normal significand adds the missing 1 back to e_adj.
    mag  = {e_adj, 10'b0} + {7'b0, mant} + {17'b0, inc};
    ovf  = mag[17:10] > 8'd30;
    tiny = mag[17:10] == 8'd0;
    rnd_flags = 5'd0;
    if (ovf) begin
      if ((rm_q == RM_RZ) || (rm_q == RM_RD && !sign_q) || (rm_q == RM_RU && sign_q))
        rnd_result = {sign_q, MAXNUM};
      else
        rnd_result = {sign_q, POS_INF[14:0]};
      rnd_flags[FLAG_OF] = 1'b1;
      rnd_flags[FLAG_NX] = 1'b1;
    end else begin
      rnd_result         = {sign_q, mag[14:0]};
      rnd_flags[FLAG_NX] = inexact;
      rnd_flags[FLAG_UF] = tiny & inexact;
    end
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    rm_d     = rm_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    eq_d     = eq_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    spec_d   = spec_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d  = x;
          y_d  = y;
          rm_d = roundmode_e'(roundmode);
`ifdef FDIV16_EARLY_OUT_EN
          if (early.hit) begin
            result_d = early.result;
            flags_d  = early.flags;
            state_d  = DONE;
          end else begin
            state_d = PREP;
          end
`else
          state_d = PREP;
`endif
        end
      end
      PREP: begin
        sign_d = x_q[15] ^ y_q[15];
        spec_d = special_case(x_q, y_q);
        div_d  = my_n;
        quo_d  = 13'd0;
        cnt_d  = 4'd0;
        // Pre-scale the dividend so the first quotient bit is always 1.
        if (mx_n < my_n) begin
          rem_d = {1'b0, mx_n, 1'b0};
          eq_d  = ex - ey + 8'(BIAS) - 8'd1;
        end else begin
          rem_d = {2'b00, mx_n};
          eq_d  = ex - ey + 8'(BIAS);
        end
        state_d = ITER;
      end
      ITER: begin
        if (rem_q >= {2'b00, div_q}) begin
          quo_d = {quo_q[11:0], 1'b1};
          rem_d = (rem_q - {2'b00, div_q}) << 1;
        end else begin
          quo_d = {quo_q[11:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) state_d = ROUND;
      end
      ROUND: begin
        if (spec_q.hit) begin
          result_d = spec_q.result;
          flags_d  = spec_q.flags;
        end else begin
          result_d = rnd_result;
          flags_d  = rnd_flags;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      rm_q     <= RM_RZ;
      rem_q    <= 13'd0;
      quo_q    <= 13'd0;
      div_q    <= 11'd0;
      eq_q     <= 8'sd0;
      cnt_q    <= 4'd0;
      sign_q   <= 1'b0;
      spec_q   <= '0;
      result_q <= 16'd0;
      flags_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rm_q     <= rm_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      eq_q     <= eq_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv16.sv
// tb/tb_fdiv16.sv - directed self-checking bench for fdiv16
module tb_fdiv16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] x = 16'd0;
  logic [15:0] y = 16'd0;
  logic [1:0]  roundmode = 2'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [4:0]  flags;

  int checks = 0;
  int failures = 0;

`ifdef FDIV16_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 15;
`endif

  fdiv16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .roundmode (roundmode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = in_ready;
    end
    check({tag, "_ready"}, 32'(seen), 32'd1);
  endtask

  // Accept one operation, scramble inputs afterwards, measure latency, check result and flags.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] rm, input logic [15:0] er, input logic [4:0] ef,
                       input int elat);
    int lat;
    wait_ready(tag);
    x = a; y = b; roundmode = rm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~a; y = 16'h1234; roundmode = ~rm;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat = c;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_flg"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    bit seen;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'h0000);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    do_op("half",        16'h3C00, 16'h4000, 2'd1, 16'h3800, 5'h00, 15);
    do_op("third_rne",   16'h3C00, 16'h4200, 2'd1, 16'h3555, 5'h01, 15);
    do_op("third_ru",    16'h3C00, 16'h4200, 2'd3, 16'h3556, 5'h01, 15);
    do_op("third_rz",    16'h3C00, 16'h4200, 2'd0, 16'h3555, 5'h01, 15);
    do_op("nthird_rd",   16'hBC00, 16'h4200, 2'd2, 16'hB556, 5'h01, 15);
    do_op("six_three",   16'h4600, 16'h4200, 2'd1, 16'h4000, 5'h00, 15);
    do_op("div_zero",    16'h4000, 16'h0000, 2'd1, 16'h7C00, 5'h08, SPEC_LAT);
    do_op("zero_zero",   16'h0000, 16'h0000, 2'd1, 16'h7E00, 5'h10, SPEC_LAT);
    do_op("snan",        16'h7D01, 16'h3C00, 2'd1, 16'h7E00, 5'h10, SPEC_LAT);
    do_op("qnan",        16'h7E00, 16'h3C00, 2'd1, 16'h7E00, 5'h00, SPEC_LAT);
    do_op("inf_inf",     16'h7C00, 16'hFC00, 2'd1, 16'h7E00, 5'h10, SPEC_LAT);
    do_op("one_ninf",    16'h3C00, 16'hFC00, 2'd1, 16'h8000, 5'h00, SPEC_LAT);
    do_op("ninf_two",    16'hFC00, 16'h4000, 2'd1, 16'hFC00, 5'h00, SPEC_LAT);
    do_op("ovf_rne",     16'h7BFF, 16'h1400, 2'd1, 16'h7C00, 5'h05, 15);
    do_op("ovf_rz",      16'h7BFF, 16'h1400, 2'd0, 16'h7BFF, 5'h05, 15);
    do_op("ovf_neg_ru",  16'hFBFF, 16'h1400, 2'd3, 16'hFBFF, 5'h05, 15);
    do_op("ovf_neg_rd",  16'hFBFF, 16'h1400, 2'd2, 16'hFC00, 5'h05, 15);
    do_op("sub_exact",   16'h0400, 16'h4000, 2'd1, 16'h0200, 5'h00, 15);
    do_op("sub_uf",      16'h0401, 16'h4000, 2'd1, 16'h0200, 5'h03, 15);
    do_op("min_sub",     16'h0001, 16'h3C00, 2'd1, 16'h0001, 5'h00, 15);
    do_op("sub_divisor", 16'h3C00, 16'h0200, 2'd1, 16'h7800, 5'h00, 15);

    // Back-pressure: result holds and new operands are refused while out_ready is low.
    wait_ready("hold");
    x = 16'h3C00; y = 16'h4000; roundmode = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (out_valid) lat = c;
    end
    check("hold_lat", 32'(lat), 32'd15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = 16'h4000; y = 16'h0000;
      #1;
      check("hold_res", 32'(result), 32'h3800);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_ov", 32'(out_valid), 32'd0);
    check("hold_release_ir", 32'(in_ready), 32'd1);
    check("hold_release_res", 32'(result), 32'h3800);

    // Reset during the sixth ITER cycle aborts the operation silently.
    wait_ready("abort");
    x = 16'h3C00; y = 16'h4200; roundmode = 2'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ov", 32'(out_valid), 32'd0);
    check("abort_res", 32'(result), 32'h0000);
    check("abort_flg", 32'(flags), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    do_op("after_abort", 16'h3C00, 16'h4000, 2'd1, 16'h3800, 5'h00, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
